// File: rtl/mmio_seg7_btn.sv
// Memory-mapped 4-digit seven-segment display driver with debounced push buttons.
// Optional IRQ_MASK register and irq_o output when MMIO_BTN_IRQ_EN is defined.
module mmio_seg7_btn #(
  parameter int unsigned          ADDR_W       = 32,
  parameter int unsigned          DATA_W       = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR    = ADDR_W'(32'h1000_0000),
  parameter int unsigned          SCAN_DIV     = 50000,
  parameter int unsigned          DEBOUNCE_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic [ADDR_W-1:0] memaddr_i,
  input  logic [DATA_W-1:0] memwdata_i,
  input  logic [3:0]        buttons_i,
  output logic [DATA_W-1:0] memrdata_o,
  output logic [6:0]        seg7_seg_o,
`ifdef MMIO_BTN_IRQ_EN
  output logic              irq_o,
`endif
  output logic [3:0]        seg7_an_o
);

`ifdef MMIO_BTN_IRQ_EN
  localparam int unsigned OFF_W = 3;
`else
  localparam int unsigned OFF_W = 2;
`endif
  localparam int unsigned DEC_LSB = OFF_W + 2;
  localparam int unsigned SC_W    = $clog2(SCAN_DIV);
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC);

  logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]        lvl_q, lvl_d, evt_q, evt_d;
  logic [DB_W-1:0]   db_cnt_q [4];
  logic [DB_W-1:0]   db_cnt_d [4];
  logic [15:0]       disp_q, disp_d;
  logic              en_q, en_d;
  logic [3:0]        blank_q, blank_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [SC_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;
`ifdef MMIO_BTN_IRQ_EN
  logic [3:0]        mask_q, mask_d;
  logic              irq_q, irq_d;
`endif

  logic             hit, rd_hit, wr_hit, digit_off;
  logic [OFF_W-1:0] off;
  logic [3:0]       nibble;
  logic             unused;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'h40;  4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;  4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;  4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;  4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;  4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;  4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;  4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;  default: hex_seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    unused = ^{memaddr_i[1:0], memwdata_i[DATA_W-1:16]};
    hit    = (memaddr_i[ADDR_W-1:DEC_LSB] == BASE_ADDR[ADDR_W-1:DEC_LSB]);
    off    = memaddr_i[DEC_LSB-1:2];
    rd_hit = memread_i && hit;
    wr_hit = memwrite_i && hit;

    sync1_d = buttons_i;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    for (int unsigned i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) lvl_d[i] = sync2_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end

    disp_d  = disp_q;
    en_d    = en_q;
    blank_d = blank_q;
    rdata_d = '0;
    evt_d   = evt_q;
`ifdef MMIO_BTN_IRQ_EN
    mask_d  = mask_q;
`endif
    // Reads observe pre-write state; new rising edges are OR'd in last so they beat any clear.
    if (rd_hit) begin
      case (off)
        OFF_W'(0): rdata_d[15:0] = disp_q;
        OFF_W'(1): begin rdata_d[0] = en_q; rdata_d[7:4] = blank_q; end
        OFF_W'(2): rdata_d[3:0] = lvl_q;
        OFF_W'(3): begin rdata_d[3:0] = evt_q; evt_d = '0; end
`ifdef MMIO_BTN_IRQ_EN
        OFF_W'(4): rdata_d[3:0] = mask_q;
`endif
        default: rdata_d = '0;
      endcase
    end
    if (wr_hit) begin
      case (off)
        OFF_W'(0): disp_d = memwdata_i[15:0];
        OFF_W'(1): begin en_d = memwdata_i[0]; blank_d = memwdata_i[7:4]; end
        OFF_W'(3): evt_d = evt_d & ~memwdata_i[3:0];
`ifdef MMIO_BTN_IRQ_EN
        OFF_W'(4): mask_d = memwdata_i[3:0];
`endif
        default: ;
      endcase
    end
    evt_d = evt_d | (lvl_d & ~lvl_q);
`ifdef MMIO_BTN_IRQ_EN
    irq_d = |(evt_q & mask_q);
`endif

    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 1'b1;
    end
    nibble    = disp_q[{idx_q, 2'b00} +: 4];
    digit_off = !en_q || blank_q[idx_q];
    an_d      = digit_off ? 4'hF : ~(4'b0001 << idx_q);
    seg_d     = digit_off ? 7'h7F : hex_seg(nibble);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      evt_q      <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt_q[i] <= '0;
      disp_q     <= '0;
      en_q       <= 1'b1;
      blank_q    <= '0;
      rdata_q    <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_q      <= 7'h7F;
      an_q       <= 4'hF;
`ifdef MMIO_BTN_IRQ_EN
      mask_q     <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_q      <= lvl_d;
      evt_q      <= evt_d;
      for (int unsigned i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
      disp_q     <= disp_d;
      en_q       <= en_d;
      blank_q    <= blank_d;
      rdata_q    <= rdata_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
`ifdef MMIO_BTN_IRQ_EN
      mask_q     <= mask_d;
      irq_q      <= irq_d;
`endif
    end
  end

  always_comb begin
    memrdata_o = rdata_q;
    seg7_seg_o = seg_q;
    seg7_an_o  = an_q;
`ifdef MMIO_BTN_IRQ_EN
    irq_o      = irq_q;
`endif
  end

endmodule

// File: tb/tb_mmio_seg7_btn.sv
// Directed self-checking bench for mmio_seg7_btn (SCAN_DIV=4, DEBOUNCE_CYC=8).
// Exercises the MMIO_BTN_IRQ_EN path too when that macro is defined.
`timescale 1ns/1ps
module tb_mmio_seg7_btn;

  localparam logic [31:0] A_DISP = 32'h1000_0000;
  localparam logic [31:0] A_CTRL = 32'h1000_0004;
  localparam logic [31:0] A_LVL  = 32'h1000_0008;
  localparam logic [31:0] A_EVT  = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread_i, memwrite_i;
  logic [31:0] memaddr_i, memwdata_i, memrdata_o;
  logic [3:0]  buttons_i, seg7_an_o;
  logic [6:0]  seg7_seg_o;
`ifdef MMIO_BTN_IRQ_EN
  logic        irq_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_seg7_btn #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h1000_0000),
    .SCAN_DIV(4), .DEBOUNCE_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .memread_i(memread_i), .memwrite_i(memwrite_i),
    .memaddr_i(memaddr_i), .memwdata_i(memwdata_i),
    .buttons_i(buttons_i), .memrdata_o(memrdata_o),
    .seg7_seg_o(seg7_seg_o),
`ifdef MMIO_BTN_IRQ_EN
    .irq_o(irq_o),
`endif
    .seg7_an_o(seg7_an_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the bus edge with the registered read data.
  task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    memread_i  = rd;
    memwrite_i = wr;
    memaddr_i  = addr;
    memwdata_i = wdata;
    @(posedge clk);
    @(negedge clk);
    memread_i  = 1'b0;
    memwrite_i = 1'b0;
    rdata      = memrdata_o;
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_xfer(1'b1, 1'b0, addr, 32'h0, d);
    check(tag, d, exp);
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    bus_xfer(1'b0, 1'b1, addr, data, d);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_an(input string tag, input logic [3:0] v);
    int n = 0;
    while (seg7_an_o !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(tag, {28'h0, seg7_an_o}, {28'h0, v});
  endtask

  initial begin
    logic [31:0] d;
    int n;
    rst = 1'b1; memread_i = 1'b0; memwrite_i = 1'b0;
    memaddr_i = '0; memwdata_i = '0; buttons_i = '0;
    tick(3);
    check("rst_an", {28'h0, seg7_an_o}, 32'hF);
    check("rst_seg", {25'h0, seg7_seg_o}, 32'h7F);
    check("rst_rdata", memrdata_o, 32'h0);
    rst = 1'b0;

    // Digit 0 enable appears on the first edge after reset, each digit held 4 cycles.
    for (int k = 0; k < 16; k++) begin
      logic [3:0] exp_an;
      @(negedge clk);
      exp_an = ~(4'b0001 << (k / 4));
      check($sformatf("scan_an_%0d", k), {28'h0, seg7_an_o}, {28'h0, exp_an});
    end

    bus_rd("ctrl_rst", A_CTRL, 32'h1);
    tick(1);
    check("rdata_idle", memrdata_o, 32'h0);
    bus_rd("disp_rst", A_DISP, 32'h0);
    bus_rd("lvl_rst", A_LVL, 32'h0);
    bus_rd("evt_rst", A_EVT, 32'h0);

    bus_wr(A_DISP, 32'hFFFF_1234);
    bus_rd("disp_rb", A_DISP, 32'h1234);
    wait_an("wait_d0", 4'hE);
    check("seg_d0", {25'h0, seg7_seg_o}, 32'h19);
    wait_an("wait_d3", 4'h7);
    check("seg_d3", {25'h0, seg7_seg_o}, 32'h79);

    bus_wr(A_CTRL, 32'hFFFF_FF21);
    bus_rd("ctrl_rb", A_CTRL, 32'h21);
    wait_an("wait_d0b", 4'hE);
    n = 0;
    while (seg7_an_o === 4'hE && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("blank_an", {28'h0, seg7_an_o}, 32'hF);
    check("blank_seg", {25'h0, seg7_seg_o}, 32'h7F);
    tick(4);
    check("d2_an", {28'h0, seg7_an_o}, 32'hB);
    check("d2_seg", {25'h0, seg7_seg_o}, 32'h24);
    bus_wr(A_CTRL, 32'h1);

    // Short glitch is rejected, long press accepted.
    buttons_i = 4'b0100;
    tick(5);
    buttons_i = 4'b0000;
    tick(12);
    bus_rd("lvl_short", A_LVL, 32'h0);
    bus_rd("evt_short", A_EVT, 32'h0);
    buttons_i = 4'b0100;
    tick(12);
    bus_rd("lvl_long", A_LVL, 32'h4);
    bus_wr(A_LVL, 32'h0);
    bus_rd("lvl_ro", A_LVL, 32'h4);
    bus_rd("evt_long", A_EVT, 32'h4);
    bus_rd("evt_rc", A_EVT, 32'h0);
    buttons_i = 4'b0000;
    tick(12);
    bus_rd("lvl_rel", A_LVL, 32'h0);
    bus_rd("evt_fall", A_EVT, 32'h0);

    // Button 0 level flips on the 10th edge after the raw change; W1C lands on that same edge.
    buttons_i = 4'b0001;
    tick(9);
    bus_wr(A_EVT, 32'h1);
    bus_rd("evt_set_wins", A_EVT, 32'h1);
    buttons_i = 4'b0011;
    tick(12);
    bus_wr(A_EVT, 32'h1);
    bus_rd("evt_w1c_keep", A_EVT, 32'h2);
    buttons_i = 4'b1011;
    tick(12);
    bus_wr(A_EVT, 32'h8);
    bus_rd("evt_w1c_clr", A_EVT, 32'h0);

    bus_xfer(1'b1, 1'b1, A_DISP, 32'h0000_ABCD, d);
    check("rw_old", d, 32'h1234);
    bus_rd("rw_new", A_DISP, 32'hABCD);
    bus_rd("miss_rd", 32'h2000_0000, 32'h0);
    bus_wr(32'h2000_0000, 32'h5555);
    bus_rd("miss_nochg", A_DISP, 32'hABCD);

    buttons_i = 4'b0000;
    tick(2);
    rst = 1'b1;
    tick(1);
    check("mrst_an", {28'h0, seg7_an_o}, 32'hF);
    check("mrst_seg", {25'h0, seg7_seg_o}, 32'h7F);
    rst = 1'b0;
    bus_rd("mrst_disp", A_DISP, 32'h0);
    bus_rd("mrst_lvl", A_LVL, 32'h0);

`ifdef MMIO_BTN_IRQ_EN
    bus_wr(32'h1000_0010, 32'h4);
    bus_rd("mask_rb", 32'h1000_0010, 32'h4);
    check("irq_idle", {31'h0, irq_o}, 32'h0);
    buttons_i = 4'b0100;
    tick(10);
    check("irq_evt_edge", {31'h0, irq_o}, 32'h0);
    tick(1);
    check("irq_set", {31'h0, irq_o}, 32'h1);
    bus_rd("irq_evt", A_EVT, 32'h4);
    tick(1);
    check("irq_clr", {31'h0, irq_o}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
